// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load funct3 codes,
// FSM states and the pending-load payload.
package wb_pkg;

    localparam int unsigned WB_XLEN      = 32;
    localparam int unsigned WB_NREG_BITS = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_NONE = 2'd3;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    // Load captured at transfer, consumed when the memory response arrives
    typedef struct packed {
        logic [WB_NREG_BITS-1:0] rd;
        logic                    we;
        logic [1:0]              off;
        logic [2:0]              funct3;
    } wb_pend_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: picks byte/half/word from a word-aligned read
// and sign- or zero-extends it. Unknown funct3 codes behave as LW.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = raw[{off, 3'b000} +: 8];
    assign half_c = off[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data_c = raw;
        case (funct3)
            LOAD_LB:  data_c = {{24{byte_c[7]}}, byte_c};
            LOAD_LBU: data_c = {24'd0, byte_c};
            LOAD_LH:  data_c = {{16{half_c[15]}}, half_c};
            LOAD_LHU: data_c = {16'd0, half_c};
            LOAD_LW:  data_c = raw;
            default:  data_c = raw;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: sole driver of the register-file write port.
// Optional WB_BYPASS_EN exposes the write being performed this cycle on byp_* ports.
module wb_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN      = WB_XLEN,
    parameter int unsigned NREG_BITS = WB_NREG_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NREG_BITS-1:0] in_rd,
    input  logic [1:0]           in_wb_sel,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [2:0]           in_funct3,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic [NREG_BITS-1:0] rf_addr_rd,
    output logic [XLEN-1:0]      rf_data_rd,
    output logic                 rf_write_enable,
    output logic                 busy
`ifdef WB_BYPASS_EN
    ,
    output logic                 byp_valid,
    output logic [NREG_BITS-1:0] byp_rd,
    output logic [XLEN-1:0]      byp_data
`endif
);

    wb_state_t             state, state_d;
    wb_pend_t              pend, pend_d;
    logic                  transfer_c;
    logic [XLEN-1:0]       direct_res_c;
    logic [XLEN-1:0]       aligned_c;
    logic                  rf_we_d;
    logic [NREG_BITS-1:0]  rf_addr_d;
    logic [XLEN-1:0]       rf_data_d;

    assign transfer_c   = in_valid & in_ready;
    assign direct_res_c = (in_wb_sel == WB_SEL_PC4) ? in_pc + XLEN'(4) : in_alu_result;

    load_align u_load_align (
        .raw    (mem_rsp_data),
        .off    (pend.off),
        .funct3 (pend.funct3),
        .data_c (aligned_c)
    );

    // Next state and next register-file write; addr/data only move when a write happens
    always_comb begin
        state_d   = state;
        pend_d    = pend;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_rd;
        rf_data_d = rf_data_rd;
        case (state)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (transfer_c) begin
                    if (in_wb_sel == WB_SEL_LOAD) begin
                        state_d = WAIT_MEM;
                        pend_d  = '{rd: in_rd, we: (in_rd != '0),
                                    off: in_alu_result[1:0], funct3: in_funct3};
                    end else begin
                        state_d = WRITE;
                        if ((in_rd != '0) && (in_wb_sel != WB_SEL_NONE)) begin
                            rf_we_d   = 1'b1;
                            rf_addr_d = in_rd;
                            rf_data_d = direct_res_c;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_d = WRITE;
                    if (pend.we) begin
                        rf_we_d   = 1'b1;
                        rf_addr_d = pend.rd;
                        rf_data_d = aligned_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered handshake and write-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pend            <= '0;
            rf_write_enable <= 1'b0;
            rf_addr_rd      <= '0;
            rf_data_rd      <= '0;
            in_ready        <= 1'b1;
            busy            <= 1'b0;
        end else begin
            state           <= state_d;
            pend            <= pend_d;
            rf_write_enable <= rf_we_d;
            rf_addr_rd      <= rf_addr_d;
            rf_data_rd      <= rf_data_d;
            in_ready        <= (state_d != WAIT_MEM);
            busy            <= (state_d != IDLE);
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_write_enable;
    assign byp_rd    = rf_addr_rd;
    assign byp_data  = rf_data_rd;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural writeback model.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        rf_write_enable;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: a load waiting for memory, whether the last edge completed an instruction
    bit          m_wait;
    bit          m_done;
    logic [4:0]  m_prd;
    logic [1:0]  m_poff;
    logic [2:0]  m_pf3;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rd           (in_rd),
        .in_wb_sel       (in_wb_sel),
        .in_alu_result   (in_alu_result),
        .in_pc           (in_pc),
        .in_funct3       (in_funct3),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd),
        .rf_write_enable (rf_write_enable),
        .busy            (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid       (byp_valid),
        .byp_rd          (byp_rd),
        .byp_data        (byp_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load result from arithmetic on the extracted field rather than bit slicing
    function automatic logic [31:0] ref_load(logic [31:0] raw, logic [1:0] off, logic [2:0] f3);
        longint unsigned b, h;
        b = (longint'(raw) >> (8 * int'(off))) % 256;
        h = (longint'(raw) >> (16 * (int'(off) / 2))) % 65536;
        case (f3)
            3'd0:    return 32'((b >= 128) ? b + 64'hFFFF_FF00 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'((h >= 32768) ? h + 64'hFFFF_0000 : h);
            3'd5:    return 32'(h);
            default: return raw;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit accept;
        accept = in_valid && !m_wait;
        e_we   = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_wait = 1'b0;
            e_addr = '0;
            e_data = '0;
        end else if (m_wait) begin
            if (mem_rsp_valid) begin
                m_wait = 1'b0;
                m_done = 1'b1;
                if (m_prd != 0) begin
                    e_we   = 1'b1;
                    e_addr = m_prd;
                    e_data = ref_load(mem_rsp_data, m_poff, m_pf3);
                end
            end
        end else if (accept) begin
            if (in_wb_sel == 2'd1) begin
                m_wait = 1'b1;
                m_prd  = in_rd;
                m_poff = in_alu_result[1:0];
                m_pf3  = in_funct3;
            end else begin
                m_done = 1'b1;
                if (in_wb_sel != 2'd3 && in_rd != 0) begin
                    e_we   = 1'b1;
                    e_addr = in_rd;
                    e_data = (in_wb_sel == 2'd2) ? in_pc + 32'd4 : in_alu_result;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("we", rf_write_enable, e_we);
        check("addr", rf_addr_rd, e_addr);
        check("data", rf_data_rd, e_data);
        check("in_ready", in_ready, !m_wait);
        check("busy", busy, m_wait || m_done);
`ifdef WB_BYPASS_EN
        check("byp_valid", byp_valid, e_we);
        check("byp_rd", byp_rd, e_addr);
        check("byp_data", byp_data, e_data);
`endif
    endtask

    task automatic set_instr(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [2:0] f3);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd         = rd;
        in_alu_result = alu;
        in_pc         = pc;
        in_funct3     = f3;
    endtask

    task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3);
        set_instr(sel, rd, alu, pc, f3);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] mem, input int delay, input logic [31:0] exp);
        send(2'd1, rd, addr, 32'h0, f3);
        mem_rsp_data = mem;
        for (int i = 1; i < delay; i++) begin
            tick();
            check("ld_wait_ready", in_ready, 1'b0);
        end
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("ld_we", rf_write_enable, 1'b1);
        check("ld_data", rf_data_rd, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_alu_result = '0;
        in_pc = '0; in_funct3 = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        m_wait = 1'b0; m_done = 1'b0; m_prd = '0; m_poff = '0; m_pf3 = '0;
        e_we = 1'b0; e_addr = '0; e_data = '0;
        tick();
        tick();
        check("rst_ready", in_ready, 1'b1);
        check("rst_we", rf_write_enable, 1'b0);
        reset = 1'b0;

        // ALU write one cycle after transfer, then deasserted
        send(2'd0, 5'd5, 32'h1234, 32'h0, 3'd0);
        check("alu_we", rf_write_enable, 1'b1);
        check("alu_addr", rf_addr_rd, 32'd5);
        check("alu_data", rf_data_rd, 32'h1234);
        tick();
        check("alu_we_off", rf_write_enable, 1'b0);

        do_load(5'd7, 32'h0000_1003, 3'd0, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        do_load(5'd7, 32'h0000_1003, 3'd4, 32'h80FF_0000, 3, 32'h0000_0080);
        do_load(5'd8, 32'h0000_2002, 3'd1, 32'h8001_7FFF, 2, 32'hFFFF_8001);
        do_load(5'd8, 32'h0000_2000, 3'd5, 32'h8001_7FFF, 1, 32'h0000_7FFF);

        // rd=0 produces no write; four back-to-back ALU ops write every cycle
        set_instr(2'd0, 5'd0, 32'hDEAD, 32'h0, 3'd0);
        tick();
        check("rd0_we", rf_write_enable, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            set_instr(2'd0, 5'(i), 32'h100 + 32'(i), 32'h0, 3'd0);
            tick();
            check("b2b_we", rf_write_enable, 1'b1);
            check("b2b_addr", rf_addr_rd, 32'(i));
        end
        in_valid = 1'b0;
        tick();

        send(2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0);
        check("pc4_wrap", rf_data_rd, 32'h0);
        send(2'd3, 5'd9, 32'h55, 32'h0, 3'd0);
        check("none_we", rf_write_enable, 1'b0);
        tick();

        // Reset while waiting for memory drops the load
        send(2'd1, 5'd10, 32'h40, 32'h0, 3'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ready", in_ready, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        check("rst_mid_we", rf_write_enable, 1'b0);
        tick();

        // Randomized traffic with spurious responses and occasional resets
        for (int c = 0; c < 3000; c++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_wb_sel     = 2'($urandom_range(0, 3));
            in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_alu_result = $urandom;
            in_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            in_funct3     = 3'($urandom);
            mem_rsp_data  = $urandom;
            mem_rsp_valid = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; mem_rsp_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
